bcd_decrementador_3digitos: RTL and testbench

- Three-digit BCD down-counter (countdown timer), 000–999, with a 7-segment output per digit.
- Parallel-loads a start value and decrements one count per enabled cycle, with borrow chained across digits.
- Flags when the count reaches zero.
- Sits beside the up-counter display blocks and drives the same three 7-segment displays, e.g. for countdown and timeout functions.

---
 rtl/bcd_decrementador_3digitos_pkg.sv | 61 ++++++
 rtl/bcd_decrementador_3digitos_if.sv | 29 ++
 rtl/bcd_bloco_dec.sv | 35 +++
 rtl/bcd_decrementador_3digitos.sv | 103 ++++++++++
 tb/tb_bcd_decrementador_3digitos.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_decrementador_3digitos_pkg.sv
// bcd_decrementador_3digitos_pkg
// Shared BCD / 7-segment definitions for the countdown and up-counter display blocks.
//   DIGIT_W, NUM_DIGITS, BCD_W, SEG_W : widths
//   SEG_0..SEG_9, SEG_BLANK           : active-low {g,f,e,d,c,b,a} patterns (common anode)
//   bcd3_t                            : {hundreds, tens, units} payload
//   seg_decode()                      : digit -> segment pattern (non-BCD codes show blank)
//   digit_clamp()                     : limits a nibble to 0..9
package bcd_decrementador_3digitos_pkg;

   localparam int unsigned DIGIT_W    = 4;
   localparam int unsigned NUM_DIGITS = 3;
   localparam int unsigned BCD_W      = DIGIT_W * NUM_DIGITS;
   localparam int unsigned SEG_W      = 7;

   localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

   typedef logic [SEG_W-1:0] seg_t;

   localparam seg_t SEG_0     = 7'b1000000;
   localparam seg_t SEG_1     = 7'b1111001;
   localparam seg_t SEG_2     = 7'b0100100;
   localparam seg_t SEG_3     = 7'b0110000;
   localparam seg_t SEG_4     = 7'b0011001;
   localparam seg_t SEG_5     = 7'b0010010;
   localparam seg_t SEG_6     = 7'b0000010;
   localparam seg_t SEG_7     = 7'b1111000;
   localparam seg_t SEG_8     = 7'b0000000;
   localparam seg_t SEG_9     = 7'b0010000;
   localparam seg_t SEG_BLANK = 7'b1111111;

   typedef struct packed {
      logic [DIGIT_W-1:0] hund;
      logic [DIGIT_W-1:0] tens;
      logic [DIGIT_W-1:0] units;
   } bcd3_t;

   // Digit to active-low segment pattern
   function automatic seg_t seg_decode(input logic [DIGIT_W-1:0] digit);
      seg_t seg;
      case (digit)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

   // Non-BCD nibbles (A..F) saturate to 9
   function automatic logic [DIGIT_W-1:0] digit_clamp(input logic [DIGIT_W-1:0] digit);
      return (digit > DIGIT_MAX) ? DIGIT_MAX : digit;
   endfunction

endpackage

// File: rtl/bcd_decrementador_3digitos_if.sv
// bcd_decrementador_3digitos_if
// Control and display bundle of the three-digit BCD countdown.
//   enb, ld, din                 : count enable, parallel load, load value (master -> slave)
//   bcd, sgm0..sgm2, cnt_zero    : count, per-digit segments, zero flag (slave -> master)
//   done                         : one-cycle pulse when a decrement reaches 000
interface bcd_decrementador_3digitos_if;
   import bcd_decrementador_3digitos_pkg::*;

   logic  enb;
   logic  ld;
   bcd3_t din;
   bcd3_t bcd;
   seg_t  sgm0;
   seg_t  sgm1;
   seg_t  sgm2;
   logic  cnt_zero;
   logic  done;

   modport master (
      output enb, ld, din,
      input  bcd, sgm0, sgm1, sgm2, cnt_zero, done
   );

   modport slave (
      input  enb, ld, din,
      output bcd, sgm0, sgm1, sgm2, cnt_zero, done
   );

endinterface

// File: rtl/bcd_bloco_dec.sv
// bcd_bloco_dec
// One BCD digit of a down-counter; chain three for a 000..999 countdown.
//   ck, rst_n : clock, async active-low reset (loads init)
//   enb       : borrow-in, decrement on this edge
//   ld, d     : synchronous load of d (clamped to 9), wins over enb
//   init      : reset value of the digit
//   q         : registered digit
//   borrow_c  : borrow-out, enb while q is 0 (combinational)
module bcd_bloco_dec
   import bcd_decrementador_3digitos_pkg::*;
(
   input  logic               ck,
   input  logic               rst_n,
   input  logic               enb,
   input  logic               ld,
   input  logic [DIGIT_W-1:0] d,
   input  logic [DIGIT_W-1:0] init,
   output logic [DIGIT_W-1:0] q,
   output logic               borrow_c
);

   // Digit register: load > decrement > hold
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         q <= init;
      end else if (ld) begin
         q <= digit_clamp(d);
      end else if (enb) begin
         q <= (q == '0) ? DIGIT_MAX : (q - DIGIT_W'(1));
      end
   end

   assign borrow_c = enb & (q == '0);

endmodule

// File: rtl/bcd_decrementador_3digitos.sv
// bcd_decrementador_3digitos
// Three-digit BCD countdown (000..999) with per-digit 7-segment outputs.
//   ck, rst_n : clock, async active-low reset (count returns to INIT)
//   bus       : slave side of bcd_decrementador_3digitos_if
//               (enb, ld, din in; bcd, sgm0..2, cnt_zero, done out)
// Parameters:
//   WRAP : 0 = hold at 000, 1 = 000 decrements to 999
//   INIT : BCD reset value, every nibble 0..9
// Build option:
//   BCD_BLANK_LEADING_ZEROS_EN : blank leading zero digits on sgm2/sgm1 (sgm0 always shown)
module bcd_decrementador_3digitos
   import bcd_decrementador_3digitos_pkg::*;
#(
   parameter bit               WRAP = 1'b0,
   parameter logic [BCD_W-1:0] INIT = 12'h000
) (
   input logic ck,
   input logic rst_n,
   bcd_decrementador_3digitos_if.slave bus
);

   localparam bcd3_t INIT_S = INIT;

   logic [DIGIT_W-1:0] q_units;
   logic [DIGIT_W-1:0] q_tens;
   logic [DIGIT_W-1:0] q_hund;
   logic               units_borrow_c;
   logic               tens_borrow_c;
   logic               hund_borrow_unused;
   logic               is_zero_c;
   logic               units_enb_c;
   logic               done_q;
   bcd3_t              cnt;

   assign cnt       = {q_hund, q_tens, q_units};
   assign is_zero_c = (cnt == BCD_W'(0));

   // Without WRAP the whole chain is frozen at 000 so no digit underflows
   assign units_enb_c = bus.enb & ~(~WRAP & is_zero_c);

   bcd_bloco_dec u_units (
      .ck       (ck),
      .rst_n    (rst_n),
      .enb      (units_enb_c),
      .ld       (bus.ld),
      .d        (bus.din.units),
      .init     (INIT_S.units),
      .q        (q_units),
      .borrow_c (units_borrow_c)
   );

   bcd_bloco_dec u_tens (
      .ck       (ck),
      .rst_n    (rst_n),
      .enb      (units_borrow_c),
      .ld       (bus.ld),
      .d        (bus.din.tens),
      .init     (INIT_S.tens),
      .q        (q_tens),
      .borrow_c (tens_borrow_c)
   );

   // Borrow out of the hundreds digit only marks the 000 -> 999 wrap; nothing consumes it
   bcd_bloco_dec u_hund (
      .ck       (ck),
      .rst_n    (rst_n),
      .enb      (tens_borrow_c),
      .ld       (bus.ld),
      .d        (bus.din.hund),
      .init     (INIT_S.hund),
      .q        (q_hund),
      .borrow_c (hund_borrow_unused)
   );

   // done pulses for the single edge that decrements 001 to 000; a load cancels it
   always_ff @(posedge ck or negedge rst_n) begin
      if (!rst_n) begin
         done_q <= 1'b0;
      end else begin
         done_q <= ~bus.ld & bus.enb & (cnt == BCD_W'(1));
      end
   end

   // Segment decode straight from the registered digits
   always_comb begin
      bus.sgm0 = seg_decode(q_units);
      bus.sgm1 = seg_decode(q_tens);
      bus.sgm2 = seg_decode(q_hund);
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      if (q_hund == '0) begin
         bus.sgm2 = SEG_BLANK;
         if (q_tens == '0) begin
            bus.sgm1 = SEG_BLANK;
         end
      end
`endif
   end

   assign bus.bcd      = cnt;
   assign bus.cnt_zero = is_zero_c;
   assign bus.done     = done_q;

endmodule

// File: tb/tb_bcd_decrementador_3digitos.sv
// tb_bcd_decrementador_3digitos
// Scoreboard bench for the BCD countdown: one saturating (WRAP=0) and one wrapping (WRAP=1)
// instance share stimulus; an integer-valued reference model predicts each edge and a
// monitor compares after every rising edge.
module tb_bcd_decrementador_3digitos;
   import bcd_decrementador_3digitos_pkg::*;

   logic ck = 1'b0;
   logic rst_n;

   always #5 ck = ~ck;

   bcd_decrementador_3digitos_if bus0 ();
   bcd_decrementador_3digitos_if bus1 ();

   bcd_decrementador_3digitos #(.WRAP(1'b0), .INIT(12'h000)) u_dut_sat (
      .ck    (ck),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   bcd_decrementador_3digitos #(.WRAP(1'b1), .INIT(12'h000)) u_dut_wrap (
      .ck    (ck),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      int v0;
      int v1;
      bit d0;
      bit d1;
   } exp_t;

   exp_t sb_q[$];

   int checks_total  = 0;
   int checks_passed = 0;

   int m_v0 = 0;
   int m_v1 = 0;
   bit m_d0 = 1'b0;
   bit m_d1 = 1'b0;

   bit count_done = 1'b0;
   int done_seen0 = 0;
   int done_seen1 = 0;

   logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks_total++;
      if (act === req) checks_passed++;
      else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
   endtask

   // Compare one instance against the integer count v and expected done d
   task automatic check_dut(input string tag, input int v, input bit d,
                            input logic [11:0] bcd, input logic done, input logic cz,
                            input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2);
      int h, t, u;
      logic [6:0] e0, e1, e2;
      h  = v / 100;
      t  = (v / 10) % 10;
      u  = v % 10;
      e0 = seg_ref[u];
      e1 = seg_ref[t];
      e2 = seg_ref[h];
`ifdef BCD_BLANK_LEADING_ZEROS_EN
      if (h == 0) e2 = 7'b1111111;
      if (h == 0 && t == 0) e1 = 7'b1111111;
`endif
      check({tag, ".bcd"},      32'(bcd),  32'(h * 256 + t * 16 + u));
      check({tag, ".done"},     32'(done), 32'(d));
      check({tag, ".cnt_zero"}, 32'(cz),   32'(v == 0));
      check({tag, ".sgm0"},     32'(s0),   32'(e0));
      check({tag, ".sgm1"},     32'(s1),   32'(e1));
      check({tag, ".sgm2"},     32'(s2),   32'(e2));
   endtask

   function automatic int clamp_val(input logic [11:0] din);
      int h, t, u;
      h = (int'(din[11:8]) > 9) ? 9 : int'(din[11:8]);
      t = (int'(din[7:4])  > 9) ? 9 : int'(din[7:4]);
      u = (int'(din[3:0])  > 9) ? 9 : int'(din[3:0]);
      return h * 100 + t * 10 + u;
   endfunction

   // Reference model: plain integer countdown
   task automatic model_step(input bit ld, input bit enb, input logic [11:0] din);
      if (ld) begin
         m_v0 = clamp_val(din);
         m_v1 = m_v0;
         m_d0 = 1'b0;
         m_d1 = 1'b0;
      end else if (enb) begin
         m_d0 = (m_v0 == 1);
         m_d1 = (m_v1 == 1);
         m_v0 = (m_v0 == 0) ? 0   : m_v0 - 1;
         m_v1 = (m_v1 == 0) ? 999 : m_v1 - 1;
      end else begin
         m_d0 = 1'b0;
         m_d1 = 1'b0;
      end
   endtask

   task automatic drive(input bit ld, input bit enb, input logic [11:0] din);
      exp_t e;
      @(negedge ck);
      bus0.ld  = ld;
      bus1.ld  = ld;
      bus0.enb = enb;
      bus1.enb = enb;
      bus0.din = din;
      bus1.din = din;
      model_step(ld, enb, din);
      e.v0 = m_v0;
      e.v1 = m_v1;
      e.d0 = m_d0;
      e.d1 = m_d1;
      sb_q.push_back(e);
      @(posedge ck);
   endtask

   // Asynchronous reset between edges; count must already read INIT before the next edge
   task automatic reset_check(input string tag);
      #2;
      rst_n = 1'b0;
      #1;
      m_v0 = 0;
      m_v1 = 0;
      m_d0 = 1'b0;
      m_d1 = 1'b0;
      check_dut({tag, ".sat"}, 0, 1'b0, bus0.bcd, bus0.done, bus0.cnt_zero,
                bus0.sgm0, bus0.sgm1, bus0.sgm2);
      check_dut({tag, ".wrap"}, 0, 1'b0, bus1.bcd, bus1.done, bus1.cnt_zero,
                bus1.sgm0, bus1.sgm1, bus1.sgm2);
      bus0.ld  = 1'b0;
      bus1.ld  = 1'b0;
      bus0.enb = 1'b0;
      bus1.enb = 1'b0;
      @(negedge ck);
      rst_n = 1'b1;
   endtask

   // Monitor: one expected entry per driven edge
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge ck);
         #1;
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check_dut("sat", e.v0, e.d0, bus0.bcd, bus0.done, bus0.cnt_zero,
                      bus0.sgm0, bus0.sgm1, bus0.sgm2);
            check_dut("wrap", e.v1, e.d1, bus1.bcd, bus1.done, bus1.cnt_zero,
                      bus1.sgm0, bus1.sgm1, bus1.sgm2);
            if (count_done) begin
               done_seen0 += int'(bus0.done);
               done_seen1 += int'(bus1.done);
            end
         end
      end
   end

   initial begin : stimulus
      rst_n    = 1'b0;
      bus0.ld  = 1'b0;
      bus1.ld  = 1'b0;
      bus0.enb = 1'b0;
      bus1.enb = 1'b0;
      bus0.din = '0;
      bus1.din = '0;

      #12;
      check_dut("reset.sat", 0, 1'b0, bus0.bcd, bus0.done, bus0.cnt_zero,
                bus0.sgm0, bus0.sgm1, bus0.sgm2);
      check_dut("reset.wrap", 0, 1'b0, bus1.bcd, bus1.done, bus1.cnt_zero,
                bus1.sgm0, bus1.sgm1, bus1.sgm2);
      @(negedge ck);
      rst_n = 1'b1;

      // Multi-digit borrow: 105 down to 099
      drive(1'b1, 1'b0, 12'h105);
      repeat (6) drive(1'b0, 1'b1, 12'h000);

      // Zero boundary: saturate vs wrap, done pulse
      drive(1'b1, 1'b0, 12'h002);
      repeat (3) drive(1'b0, 1'b1, 12'h000);
      drive(1'b0, 1'b0, 12'h000);

      // Load priority and clamping
      drive(1'b1, 1'b1, 12'h350);
      drive(1'b1, 1'b0, 12'hFAC);
      drive(1'b1, 1'b0, 12'h001);
      drive(1'b1, 1'b1, 12'h000);
      drive(1'b1, 1'b0, 12'h001);
      drive(1'b0, 1'b1, 12'h000);
      drive(1'b1, 1'b0, 12'h000);

      // Leading-zero display cases
      drive(1'b1, 1'b0, 12'h007);
      drive(1'b0, 1'b0, 12'h000);
      drive(1'b1, 1'b0, 12'h000);
      drive(1'b1, 1'b0, 12'h040);

      // Reset mid-count, then reset right after a done pulse
      drive(1'b1, 1'b0, 12'h456);
      reset_check("rst_mid");
      drive(1'b1, 1'b0, 12'h001);
      drive(1'b0, 1'b1, 12'h000);
      reset_check("rst_done");

      // Full sweep 999 -> 000 and past the boundary
      drive(1'b1, 1'b0, 12'h999);
      count_done = 1'b1;
      repeat (999) drive(1'b0, 1'b1, 12'h000);
      repeat (2) drive(1'b0, 1'b1, 12'h000);
      #2;
      count_done = 1'b0;
      check("sweep.done_pulses.sat", 32'(done_seen0), 32'd1);
      check("sweep.done_pulses.wrap", 32'(done_seen1), 32'd1);

      // Randomized traffic with small loads so the zero boundary recurs
      repeat (400) begin
         logic [11:0] r;
         r = 12'($urandom);
         if ($urandom_range(0, 1) == 0) r[11:4] = 8'h00;
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, r);
      end

      @(posedge ck);
      #2;
      check("scoreboard.drained", 32'(sb_q.size()), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
